// File: rtl/mem_arbiter.sv
// Two-requester cache-line burst arbiter: icache refills and dcache refills/writebacks
// share one memory port; ties alternate using the last grant.
module mem_arbiter #(
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned AW        = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ic_req,
   input  logic [AW-1:0]                ic_addr,
   output logic [31:0]                  ic_rdata,
   output logic                         ic_rvalid,
   output logic                         ic_done,
   input  logic                         dc_req,
   input  logic                         dc_we,
   input  logic [AW-1:0]                dc_addr,
   input  logic [31:0]                  dc_wdata,
   output logic [31:0]                  dc_rdata,
   output logic                         dc_rvalid,
   output logic                         dc_wready,
   output logic                         dc_done,
   output logic [$clog2(BURST_LEN)-1:0] beat,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [AW-1:0]                mem_addr,
   output logic [31:0]                  mem_wdata,
   input  logic                         mem_ack,
   input  logic [31:0]                  mem_rdata
);

   localparam int unsigned BW = $clog2(BURST_LEN);
   localparam int unsigned OW = BW + 2;
   localparam logic [AW-1:0] LINE_MASK = ~((AW'(1) << OW) - AW'(1));
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
   localparam logic LG_I = 1'b0;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;

   state_e          state_q, state_d;
   logic            last_grant_q;
   logic            we_q;
   logic [AW-1:0]   base_q;
   logic            grant_i, grant_d, last_ack, busy;
   logic [BW-1:0]   beat_nx;
   logic [AW-1:0]   sel_base;

   assign busy     = (state_q == BUSY_I) || (state_q == BUSY_D);
   assign beat_nx  = beat + BW'(1);
   assign sel_base = (grant_d ? dc_addr : ic_addr) & LINE_MASK;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state, grant decision and final-beat detection
   always_comb begin
      state_d  = state_q;
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      last_ack = 1'b0;
      case (state_q)
         IDLE: begin
            if (ic_req && dc_req) begin
               if (last_grant_q == LG_I) grant_d = 1'b1;
               else                      grant_i = 1'b1;
            end else if (ic_req) begin
               grant_i = 1'b1;
            end else if (dc_req) begin
               grant_d = 1'b1;
            end
            if (grant_i)      state_d = BUSY_I;
            else if (grant_d) state_d = BUSY_D;
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack && (beat == LAST_BEAT)) begin
               last_ack = 1'b1;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: grant latches, beat counter, memory request and done pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= LG_I;
         we_q         <= 1'b0;
         base_q       <= '0;
         beat         <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         ic_done      <= 1'b0;
         dc_done      <= 1'b0;
      end else begin
         ic_done <= last_ack && (state_q == BUSY_I);
         dc_done <= last_ack && (state_q == BUSY_D);
         if (grant_i || grant_d) begin
            last_grant_q <= grant_d;
            we_q         <= grant_d & dc_we;
            base_q       <= sel_base;
            mem_addr     <= sel_base;
            beat         <= '0;
            mem_req      <= 1'b1;
            mem_we       <= grant_d & dc_we;
         end else if (busy && mem_ack) begin
            beat     <= beat_nx;
            mem_addr <= base_q + AW'({beat_nx, 2'b00});
            if (last_ack) begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         end
      end
   end

   // Beat strobes follow the memory ack in the same cycle
   assign ic_rvalid = mem_ack && (state_q == BUSY_I);
   assign dc_rvalid = mem_ack && (state_q == BUSY_D) && !we_q;
   assign dc_wready = mem_ack && (state_q == BUSY_D) && we_q;
   assign ic_rdata  = mem_rdata;
   assign dc_rdata  = mem_rdata;
   assign mem_wdata = dc_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected beats/done pulses,
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_mem_arbiter;

   localparam int unsigned BL = 4;
   localparam int unsigned AW = 32;

   localparam logic [2:0] K_IR = 3'd1;
   localparam logic [2:0] K_DR = 3'd2;
   localparam logic [2:0] K_DW = 3'd3;
   localparam logic [2:0] K_ID = 3'd4;
   localparam logic [2:0] K_DD = 3'd5;

   typedef struct {
      logic [2:0]  kind;
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } exp_t;

   logic          clk, rst_n;
   logic          ic_req, dc_req, dc_we, mem_ack;
   logic [AW-1:0] ic_addr, dc_addr;
   logic [31:0]   dc_wdata, mem_rdata;
   logic [31:0]   ic_rdata, dc_rdata, mem_wdata;
   logic          ic_rvalid, ic_done, dc_rvalid, dc_wready, dc_done;
   logic [1:0]    beat;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   mem_arbiter #(.BURST_LEN(BL), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
      .ic_rvalid(ic_rvalid), .ic_done(ic_done),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_wready(dc_wready),
      .dc_done(dc_done), .beat(beat),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the oldest expected entry
   always @(negedge clk) begin
      logic [2:0]  ok;
      logic [31:0] od;
      exp_t        e;
      if (rst_n && (ic_rvalid || dc_rvalid || dc_wready || ic_done || dc_done)) begin
         ok = ic_rvalid ? K_IR : dc_rvalid ? K_DR : dc_wready ? K_DW : ic_done ? K_ID : K_DD;
         od = ic_rvalid ? ic_rdata : dc_rvalid ? dc_rdata : dc_wready ? mem_wdata : 32'h0;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_strobe: got kind %0d expected none", ok);
         end else begin
            e = exp_q.pop_front();
            if ($countones({ic_rvalid, dc_rvalid, dc_wready, ic_done, dc_done}) != 1 ||
                ok != e.kind ||
                (ok <= K_DW && (mem_addr != e.addr || mem_we != e.we || od != e.data))) begin
               n_bad++;
               $display("FAIL strobe: got kind %0d addr 0x%08h we %0b data 0x%08h expected kind %0d addr 0x%08h we %0b data 0x%08h",
                        ok, mem_addr, mem_we, od, e.kind, e.addr, e.we, e.data);
            end
         end
      end
   end

   // Serve a granted burst; call at posedge+1 right after the grant edge
   task automatic serve(input bit is_d, input bit we, input logic [31:0] base,
                        input int gap, input int drop_at, input int n_beats);
      exp_t e;
      for (int i = 0; i < n_beats; i++) begin
         for (int g = 0; g < gap; g++) begin
            mem_ack = 1'b0;
            check("stall_req", 32'(mem_req), 32'd1);
            check("stall_addr", mem_addr, base + 32'(i * 4));
            @(posedge clk); #1;
         end
         check("beat_idx", 32'(beat), 32'(i));
         check("beat_addr", mem_addr, base + 32'(i * 4));
         e.kind = is_d ? (we ? K_DW : K_DR) : K_IR;
         e.addr = base + 32'(i * 4);
         e.we   = we;
         if (we) begin
            dc_wdata  = 32'h1111_0000 + 32'(i);
            mem_rdata = 32'hDEAD_BEEF;
            e.data    = 32'h1111_0000 + 32'(i);
         end else begin
            mem_rdata = 32'hCAFE_0000 ^ e.addr;
            e.data    = 32'hCAFE_0000 ^ e.addr;
         end
         exp_q.push_back(e);
         mem_ack = 1'b1;
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (i == drop_at) begin
            if (is_d) dc_req = 1'b0;
            else      ic_req = 1'b0;
         end
      end
      if (n_beats == BL) begin
         e.kind = is_d ? K_DD : K_ID;
         e.addr = 32'h0; e.we = 1'b0; e.data = 32'h0;
         exp_q.push_back(e);
         check("req_low_in_done", 32'(mem_req), 32'd0);
         check("beat_wrapped", 32'(beat), 32'd0);
         if (is_d) dc_req = 1'b0;
         else      ic_req = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ack = 1'b0;
      ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;

      // Asynchronous reset, checked before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_beat", 32'(beat), 32'd0);
      check("rst_dones", 32'({ic_done, dc_done}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Spurious acks while idle
      mem_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("spur_rvalid", 32'({ic_rvalid, dc_rvalid, dc_wready}), 32'd0);
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      check("spur_beat", 32'(beat), 32'd0);
      check("spur_req", 32'(mem_req), 32'd0);

      // Single icache refill, ack every cycle
      ic_req = 1'b1; ic_addr = 32'h0000_1234;
      check("pre_grant_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      check("grant_mem_req", 32'(mem_req), 32'd1);
      serve(1'b0, 1'b0, 32'h0000_1230, 0, -1, BL);

      // Contention: D first, then ties alternate
      ic_req = 1'b1; ic_addr = 32'h0000_2000;
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_3008;
      @(posedge clk); #1;
      serve(1'b1, 1'b0, 32'h0000_3000, 0, -1, BL);
      dc_req = 1'b1; dc_addr = 32'h0000_3044;
      @(posedge clk); #1;
      serve(1'b0, 1'b0, 32'h0000_2000, 0, -1, BL);
      ic_req = 1'b1; ic_addr = 32'h0000_2010;
      @(posedge clk); #1;
      serve(1'b1, 1'b0, 32'h0000_3040, 0, -1, BL);
      @(posedge clk); #1;
      serve(1'b0, 1'b0, 32'h0000_2010, 0, -1, BL);

      // Writeback with alternate-cycle acks; address change after grant ignored
      dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0080;
      @(posedge clk); #1;
      dc_addr = 32'hFFFF_FFF0; dc_we = 1'b0;
      check("wb_mem_we", 32'(mem_we), 32'd1);
      serve(1'b1, 1'b1, 32'h0000_0080, 1, -1, BL);
      check("wb_we_cleared", 32'(mem_we), 32'd0);

      // Refill with request dropped after beat 1
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_04C4;
      @(posedge clk); #1;
      serve(1'b1, 1'b0, 32'h0000_04C0, 0, 1, BL);

      // Reset mid-burst at beat 2
      ic_req = 1'b1; ic_addr = 32'h0000_0510;
      @(posedge clk); #1;
      serve(1'b0, 1'b0, 32'h0000_0510, 0, -1, 2);
      check("pre_rst_beat", 32'(beat), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_mem_req", 32'(mem_req), 32'd0);
      check("midrst_beat", 32'(beat), 32'd0);
      check("midrst_rvalid", 32'({ic_rvalid, ic_done}), 32'd0);
      ic_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("post_rst_done", 32'({ic_done, dc_done}), 32'd0);
      ic_req = 1'b1; ic_addr = 32'h0000_061C;
      check("post_rst_no_grant", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      serve(1'b0, 1'b0, 32'h0000_0610, 0, -1, BL);

      repeat (3) @(posedge clk);
      #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning words per cache-line burst (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ic_req in 1 (icache refill request) and ic_addr in AW (miss address).
REQ-006 SHALL have ports ic_rdata out 32, ic_rvalid out 1 (read beat valid) and ic_done out 1 (burst complete).
REQ-007 SHALL have ports dc_req in 1, dc_we in 1 (1 = writeback, 0 = refill), dc_addr in AW and dc_wdata in 32 (current write beat).
REQ-008 SHALL have ports dc_rdata out 32, dc_rvalid out 1, dc_wready out 1 (write beat accepted) and dc_done out 1.
REQ-009 SHALL have port beat  out  log2(BURST_LEN)  index of the current burst word.
REQ-010 SHALL have memory-side ports mem_req out 1, mem_we out 1, mem_addr out AW, mem_wdata out 32, mem_ack in 1 and mem_rdata in 32.

Function
REQ-011 SHALL implement states IDLE, BUSY_I, BUSY_D and DONE.
REQ-012 IDLE: ic_req only -> BUSY_I; dc_req only -> BUSY_D; both -> grant the requester not granted last; neither -> stay in IDLE.
REQ-013 SHALL hold a last_grant register, updated on every IDLE->BUSY transition.
REQ-014 SHALL latch the granted address and dc_we on the grant edge; requester changes after grant are ignored until DONE.
REQ-015 Line base SHALL be the latched address with the low log2(BURST_LEN)+2 bits cleared.
REQ-016 mem_addr SHALL equal base + beat*4.
REQ-017 mem_req SHALL be registered high from the cycle after the grant until the final ack; mem_we SHALL equal the latched dc_we in BUSY_D and 0 in BUSY_I.
REQ-018 Each cycle with mem_req and mem_ack high SHALL advance beat by 1; mem_addr SHALL update the following cycle.
REQ-019 Ack with beat == BURST_LEN-1 SHALL move the state to DONE and reset beat to 0 (wrap).
REQ-020 ic_rvalid SHALL be mem_ack & BUSY_I (combinational); ic_rdata SHALL be mem_rdata.
REQ-021 dc_rvalid SHALL be mem_ack & BUSY_D & !we; dc_wready SHALL be mem_ack & BUSY_D & we; mem_wdata SHALL be dc_wdata.
REQ-022 DONE SHALL last exactly one cycle, pulse the granted requester's done (registered), ignore all requests and return to IDLE.
REQ-023 Requesters SHALL drop req in the done cycle; a req still high in IDLE SHALL be treated as a new request.
REQ-024 Deassertion of a req mid-burst SHALL NOT abort the burst; all BURST_LEN beats SHALL complete.
REQ-025 mem_ack outside BUSY_I/BUSY_D SHALL be ignored.
REQ-026 Minimum burst latency SHALL be grant edge + BURST_LEN ack cycles + 1 DONE cycle.
REQ-027 An unbounded mem_ack stall SHALL hold state, beat and mem_addr unchanged.

Reset
REQ-028 On rst_n low, state SHALL go to IDLE, beat to 0 and last_grant to I (dcache wins the first contention), immediately and irrespective of the clock.
REQ-029 While rst_n is low, mem_req, mem_we, ic_done, dc_done, ic_rvalid, dc_rvalid and dc_wready SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no done pulse.
REQ-031 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge.

Verification
REQ-032 Single refill: ic_req, ic_addr=0x0000_1234, ack every cycle -> mem_addr 0x1230, 0x1234, 0x1238, 0x123C; 4 ic_rvalid; ic_done one cycle after the 4th ack.
REQ-033 Contention after reset: ic_req and dc_req high together -> D granted first, then I; a repeated tie -> D.
REQ-034 Writeback: dc_we=1, dc_addr=0x80, ack on alternate cycles -> mem_we=1, 4 dc_wready pulses, mem_addr steps only after each ack, dc_done once.
REQ-035 Mid-burst req drop: dc_req low after beat 1 -> beats 2 and 3 still issued, dc_done pulsed.
REQ-036 Reset at beat 2 -> mem_req 0 asynchronously, no done; a new ic_req after reset starts at beat 0.
REQ-037 Spurious mem_ack in IDLE -> no rvalid, beat stays at 0.
